// File: rtl/sync_fifo_ram_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_ram.
// The master modport is the user side, the slave modport is the FIFO side.
// The overflow/underflow flags exist only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 4
);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_SIZE:0]    count;
`ifdef SYNC_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface : sync_fifo_ram_if

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO around a dual-port memory array: pointer management,
// occupancy count, almost-full/almost-empty thresholds, a registered read
// port with a valid strobe and a synchronous flush.
// Optional feature: define SYNC_FIFO_ERR_EN to add sticky overflow/underflow
// flags on the interface; without it rejected requests are silently dropped.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 4,
  parameter int AFULL_TH   = (1 << ADDR_SIZE) - 2,
  parameter int AEMPTY_TH  = 2
) (
  input logic              clk,
  input logic              rstn,
  sync_fifo_ram_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Thresholds and depth expressed at count width so every compare is
  // width-matched; legal threshold ranges fit in ADDR_SIZE+1 bits.
  localparam logic [ADDR_SIZE:0] DEPTH_LVL  = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_LVL  = (ADDR_SIZE + 1)'(AFULL_TH);
  localparam logic [ADDR_SIZE:0] AEMPTY_LVL = (ADDR_SIZE + 1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_SIZE-1:0]  wr_ptr;
  logic [ADDR_SIZE-1:0]  rd_ptr;
  logic [ADDR_SIZE:0]    count_q;
  logic [ADDR_SIZE:0]    count_next;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  clear;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status decoded from the registered count, so it reflects operations
  // accepted on the previous edge.
  assign full_w  = (count_q == DEPTH_LVL);
  assign empty_w = (count_q == '0);

  // Reset and flush both suppress any request arriving in the same cycle.
  assign clear  = !rstn || bus.flush;
  assign wr_acc = bus.wr_en && !full_w && !clear;
  assign rd_acc = bus.rd_en && !empty_w && !clear;

  // Next occupancy: a simultaneous accepted read and write cancel out.
  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Storage write port.
  // NOTE: the array has no reset; pointers and count define which entries
  // are live, so stale words after reset/flush are never observable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  // NOTE: reset is synchronous here, so it is tested inside the clocked
  // block and never appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_next;
    end
  end

  // Registered read data: cleared by reset only, held across flush and
  // whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (rd_acc) begin
      rd_data_q <= mem[rd_ptr];
    end
  end

  // Read-valid strobe: one cycle per accepted read, dropped by reset/flush.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AFULL_LVL);
  assign bus.almost_empty = (count_q <= AEMPTY_LVL);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags; a flush or reset in the same cycle wins over a set.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule : sync_fifo_ram

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench for sync_fifo_ram: directed test-plan steps followed by
// a randomized phase, all compared against a queue-based reference model.
module tb_sync_fifo_ram;

  localparam int DW    = 16;
  localparam int AS    = 4;
  localparam int DEPTH = 1 << AS;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic clk;
  logic rstn;

  sync_fifo_ram_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) bus ();

  sync_fifo_ram #(
    .DATA_WIDTH(DW),
    .ADDR_SIZE (AS),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: FIFO contents as a queue plus output expectations.
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid;
  logic          m_ovf;
  logic          m_udf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all(input string ctx);
    int n;
    n = q.size();
    check({ctx, ":count"},        32'(bus.count),        32'(n));
    check({ctx, ":full"},         32'(bus.full),         32'(n == DEPTH));
    check({ctx, ":empty"},        32'(bus.empty),        32'(n == 0));
    check({ctx, ":almost_full"},  32'(bus.almost_full),  32'(n >= AF_TH));
    check({ctx, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_TH));
    check({ctx, ":rd_valid"},     32'(bus.rd_valid),     32'(m_rd_valid));
    check({ctx, ":rd_data"},      32'(bus.rd_data),      32'(m_rd_data));
`ifdef SYNC_FIFO_ERR_EN
    check({ctx, ":overflow"},     32'(bus.overflow),     32'(m_ovf));
    check({ctx, ":underflow"},    32'(bus.underflow),    32'(m_udf));
`endif
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs, input string ctx);
    bit full_now, empty_now;
    @(negedge clk);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.flush   = f;
    rstn        = rs;
    @(posedge clk);
    full_now  = (q.size() == DEPTH);
    empty_now = (q.size() == 0);
    if (!rs) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else if (f) begin
      q.delete();
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      if (w && full_now)  m_ovf = 1'b1;
      if (r && empty_now) m_udf = 1'b1;
      if (r && !empty_now) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (w && !full_now) q.push_back(d);
    end
    #1;
    check_all(ctx);
  endtask

  task automatic wr(input logic [DW-1:0] d, input string ctx);
    step(1'b1, d, 1'b0, 1'b0, 1'b1, ctx);
  endtask

  task automatic rd(input string ctx);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, ctx);
  endtask

  task automatic wr_rd(input logic [DW-1:0] d, input string ctx);
    step(1'b1, d, 1'b1, 1'b0, 1'b1, ctx);
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #1ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [DW-1:0] held;
    rstn        = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    m_rd_data   = '0;
    m_rd_valid  = 1'b0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;

    // Reset values.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, "reset");

    // Fill 0x0001..0x0010; almost_full at 14, full at 16, 17th write dropped.
    for (int i = 1; i <= DEPTH; i++) wr(DW'(i), "fill");
    check("fill:full_explicit", 32'(bus.full), 32'd1);
    wr(16'h00FF, "overfill");

    // Drain in order, then one read on empty.
    for (int i = 1; i <= DEPTH; i++) begin
      rd("drain");
      check("drain:order", 32'(bus.rd_data), 32'(i));
    end
    rd("underread");
    check("underread:no_valid", 32'(bus.rd_valid), 32'd0);

    // Pointer wrap: 10 in, 10 out, then 0xA0..0xA9 across index 15->0.
    for (int i = 0; i < 10; i++) wr(DW'($urandom), "wrap_w1");
    for (int i = 0; i < 10; i++) rd("wrap_r1");
    for (int i = 0; i < 10; i++) wr(DW'(16'hA0 + i), "wrap_w2");
    for (int i = 0; i < 10; i++) begin
      rd("wrap_r2");
      check("wrap:data", 32'(bus.rd_data), 32'(16'hA0 + i));
    end

    // Simultaneous read/write at count 5, at empty, and at full.
    for (int i = 0; i < 5; i++) wr(DW'($urandom), "sim_fill5");
    wr_rd(16'h1234, "sim_at5");
    check("sim_at5:count", 32'(bus.count), 32'd5);
    for (int i = 0; i < 5; i++) rd("sim_drain");
    wr_rd(16'h5678, "sim_at_empty");
    check("sim_at_empty:count", 32'(bus.count), 32'd1);
    for (int i = 0; i < DEPTH - 1; i++) wr(DW'($urandom), "sim_fill_full");
    wr_rd(16'hDEAD, "sim_at_full");
    check("sim_at_full:count", 32'(bus.count), 32'(DEPTH - 1));

    // Flush at count 7 with rd_en high; rd_data must hold.
    while (q.size() > 7) rd("to7");
    held = bus.rd_data;
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, "flush");
    check("flush:rd_data_held", 32'(bus.rd_data), 32'(held));

    // Reset for one cycle at count 9, then fresh data must come back.
    for (int i = 0; i < 9; i++) wr(DW'($urandom), "to9");
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0, "mid_reset");
    for (int i = 0; i < 4; i++) wr(DW'(16'hC0 + i), "post_reset_w");
    for (int i = 0; i < 4; i++) begin
      rd("post_reset_r");
      check("post_reset:data", 32'(bus.rd_data), 32'(16'hC0 + i));
    end
    rd("post_reset_empty");

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      logic w, r, f, rs;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      f  = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 149) != 0);
      step(w, DW'($urandom), r, f, rs, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo_ram

// File: doc/sync_fifo_ram.md
# sync_fifo_ram

Parametrised single-clock FIFO built around an internal dual-port memory array, the successor to the team's bare dual-port RAM. It adds pointer management, occupancy count, programmable almost-full/almost-empty thresholds, a registered read port with a valid strobe, and a synchronous flush. It is used as the per-channel buffer inside the crossbar datapath, where producer and consumer share one clock.

## Interface
- DATA_WIDTH, 16, width of each stored word
- ADDR_SIZE, 4, log2 of depth; DEPTH = 1 << ADDR_SIZE
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rstn  in  1  reset; synchronous, active-low
- flush  in  1  synchronous clear of FIFO state
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read word
- rd_valid  out  1  rd_data was loaded by a read accepted in the previous cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags; present only with SYNC_FIFO_ERR_EN

## Operation
- Write is accepted iff wr_en && !full. Full is the registered value at the start of the cycle. mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read is accepted iff rd_en && !empty. rd_data <= mem[rd_ptr] and rd_ptr increments.
- Pointers are ADDR_SIZE bits wide and wrap from DEPTH-1 to 0 naturally.
- Count update: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Simultaneous write and read when full: the read is accepted, the write is rejected, and count becomes DEPTH-1.
- Simultaneous write and read when empty: the write is accepted, the read is rejected, and count becomes 1.
- No fall-through: a word written in cycle N is readable no earlier than cycle N+1.
- Priority is rstn > flush > normal operation.
- Reset or flush: wr_ptr, rd_ptr and count go to 0, and rd_valid goes to 0. Memory contents are not cleared; there is no per-entry reset loop. A read request or write request in the same cycle is ignored.
- rd_data holds its last value when no read is accepted. Reset sets rd_data to 0; flush does not change it.

## Timing
- Read latency is 1 cycle: a read accepted at edge N gives valid rd_data, with rd_valid=1, after edge N, for exactly one cycle per accepted read.
- full, empty, almost_full, almost_empty and count are registered (or decoded from registered count) and reflect accepted operations 1 cycle later.
- Back-to-back reads sustain 1 word per cycle, as do back-to-back writes.
- Reset values: rd_data=0, rd_valid=0, full=0, empty=1, count=0. almost_empty=1. almost_full=0 when AFULL_TH >= 1. overflow=0 and underflow=0.
- Reset applied mid-operation takes effect at the next edge. In-flight rd_valid is dropped.

## Configuration
- SYNC_FIFO_ERR_EN defined: the overflow and underflow ports exist.
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both are sticky until rstn or flush; flush in the same cycle wins.
  - Set timing is 1 cycle after the offending request.
- SYNC_FIFO_ERR_EN undefined: the ports and logic are absent. Rejected requests are silently dropped, and all other behaviour is identical.

## Test plan
- Reset, then write 0x0001..0x0010 (DEPTH=16):
  - full=1 and count=16 one cycle after the 16th write.
  - almost_full rises when count reaches 14.
  - A 17th write is dropped, and overflow=1 if SYNC_FIFO_ERR_EN is defined.
- From full, read 16 words: rd_data is 0x0001..0x0010 in order, each with rd_valid one cycle after rd_en. empty=1 after the last read, and a further rd_en gives rd_valid=0 (underflow=1 if enabled).
- Pointer wrap: write 10 words, read 10 words, then write 10 more (0xA0..0xA9) and read them back. Data is correct across the index 15→0 wrap, and count is never above 10.
- Simultaneous read and write:
  - At count=5: count stays 5.
  - At empty: count goes to 1 and rd_valid=0.
  - At full: count goes to 15 and the write is dropped.
- Flush at count=7 while rd_en=1: next cycle count=0, empty=1, rd_valid=0 and rd_data unchanged. Error flags are cleared.
- Assert rstn=0 for one cycle mid-stream at count=9: all outputs return to their reset values. Subsequently written data reads back correctly; stale entries are never output.
